// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the NN datapath blocks.
//   fx_t           : raw fixed-point word (FX_IL integer + FX_FL fractional bits)
//   FX_ZERO        : all-zero fixed-point word
//   unpool_state_e : control states of the max-unpooling expander
package nn_fixed_pkg;

  localparam int unsigned FX_IL = 8;
  localparam int unsigned FX_FL = 12;
  localparam int unsigned FX_W  = FX_IL + FX_FL;

  typedef logic [FX_W-1:0] fx_t;

  localparam fx_t FX_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } unpool_state_e;

endpackage

// File: rtl/max_unpooling.sv
// Max-unpooling expander: takes one pooled value plus its argmax index and
// streams a size-element window with the value at the argmax slot, zeros
// elsewhere. The full window is also collected in om; done pulses once the
// last element has been handed off.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : allows a new window to be accepted (IDLE only)
//   in_valid/in_ready   : input handshake for in_val/in_idx
//   out_valid/out_ready : output handshake for out_val/out_pos/out_last
//   om                  : collected window, complete when done=1
//   done                : one-cycle pulse after the last output handshake
module max_unpooling
  import nn_fixed_pkg::*;
#(
  parameter int unsigned IL    = FX_IL,
  parameter int unsigned FL    = FX_FL,
  parameter int unsigned size  = 4,
  parameter int unsigned width = $clog2(size)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IL+FL-1:0] in_val,
  input  logic [width-1:0] in_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IL+FL-1:0] out_val,
  output logic [width-1:0] out_pos,
  output logic             out_last,
  output logic [IL+FL-1:0] om [size],
  output logic             done
);

  localparam int unsigned      W    = IL + FL;
  localparam logic [width-1:0] LAST = width'(size - 1);

  unpool_state_e    state;
  unpool_state_e    state_nxt;
  logic [width-1:0] ptr;
  logic [W-1:0]     val_q;
  logic [width-1:0] idx_q;
  logic             armed;
  logic             accept;
  logic             hs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_val   = W'(FX_ZERO);
    out_pos   = ptr;
    done      = 1'b0;
    accept    = 1'b0;
    hs        = 1'b0;
    unique case (state)
      IDLE: begin
        // armed keeps in_ready low while reset is held and for the first cycle after
        in_ready = en & armed;
        accept   = in_valid & in_ready;
        if (accept) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (ptr == LAST);
        // an out-of-range index never matches, so the window comes out all zero
        out_val   = (ptr == idx_q) ? val_q : W'(FX_ZERO);
        hs        = out_ready;
        if (hs && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched window, element pointer and collected output array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      ptr   <= '0;
      val_q <= '0;
      idx_q <= '0;
      for (int unsigned i = 0; i < size; i++) om[i] <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        val_q <= in_val;
        idx_q <= in_idx;
        ptr   <= '0;
        for (int unsigned i = 0; i < size; i++) om[i] <= '0;
      end else if (hs) begin
        om[ptr] <= out_val;
        ptr     <= out_last ? '0 : ptr + width'(1);
      end
    end
  end

endmodule
